dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Single-owner controller for the data memory's one read/write port.
- Arbitrates between the CPU load/store/PUSH/POP path (cpu_*) and a host loader/debug path (host_*), round-robin on contention.
- Contains a clear engine that zero-fills the whole memory on command; the memory itself has no working reset, so this engine is the only way to initialise it.
- Sits between the pipeline's MEM stage and the data memory.

Parameters:
DATA_W, 32, data word width
ADDR_W, 10, number of significant address bits forwarded to memory
DEPTH, 1024, words zero-filled by the clear engine (must be ≤ 2^ADDR_W)

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  32  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse to the CPU
cpu_rdata  out  DATA_W  CPU read result; valid when cpu_ack is high, held until the next CPU read
host_req, host_we, host_addr, host_wdata  in  1/1/32/DATA_W  host request, same semantics as the cpu_* inputs
host_ack, host_rdata  out  1/DATA_W  host completion pulse and read result, same semantics as cpu_ack/cpu_rdata
clear_start  in  1  one-cycle pulse that requests a zero-fill
clear_busy  out  1  high while the zero-fill is in progress
clear_done  out  1  one-cycle pulse when the zero-fill finishes
busy  out  1  high in SERVE or CLEAR
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
mem_addr  out  32  memory address; bits [31:ADDR_W] are always 0
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Reset: state IDLE. All outputs are 0, including both rdata registers. last_grant = HOST, so the CPU wins the first tie. clear_pending = 0.
- Reset during CLEAR aborts the fill; memory contents are left partially cleared and no clear_done is issued.
- FSM states: IDLE, SERVE, CLEAR.
- IDLE, checked in this order:
  - If clear_start or clear_pending: go to CLEAR, set clr_addr = 0, clear clear_pending.
  - Otherwise form eligible requesters, where a requester is eligible if its req = 1 and its ack = 0 this cycle. Masking the acked requester prevents a held req from re-issuing.
  - One eligible requester: grant it. Two eligible: grant the one that is not last_grant.
  - On grant: latch the winner's we, addr[ADDR_W-1:0] and wdata; update last_grant; go to SERVE.
  - No eligible requester: stay in IDLE. mem_read = mem_write = 0 in IDLE.
- SERVE (exactly one cycle):
  - Drive mem_addr = {0, latched addr}, mem_write = we, mem_read = !we, mem_wdata = latched wdata.
  - At the closing posedge, reads capture mem_rdata into the winner's rdata; writes leave rdata unchanged.
  - Set the winner's ack = 1 for the next cycle only, then return to IDLE.
- Latency: req sampled in IDLE at cycle N → memory access in cycle N+1 → ack in cycle N+2. In cycle N+2 the arbiter can already grant the other requester. Minimum issue interval for a single requester is 3 cycles.
- CLEAR:
  - Each cycle drive mem_write = 1, mem_read = 0, mem_wdata = 0, mem_addr = clr_addr, then increment clr_addr.
  - When clr_addr == DEPTH-1 (that word is still written): go to IDLE and pulse clear_done the next cycle.
  - clear_busy = 1 throughout CLEAR. Requests are not granted and simply wait.
  - clear_start sampled at cycle T → writes in cycles T+1..T+DEPTH → clear_done at T+DEPTH+1.
- clear_start received in SERVE sets clear_pending. clear_start received in CLEAR is ignored.
- Simultaneous clear_start and req in IDLE: clear wins and the request waits.
- Address bits above ADDR_W are dropped, so they wrap modulo 2^ADDR_W.

Test Plan:
- Reset, then cpu_req write addr 5 data 0xDEADBEEF → mem_write = 1 / mem_addr = 5 in cycle 1 → cpu_ack in cycle 2. Then a CPU read of addr 5 → cpu_rdata = 0xDEADBEEF on cpu_ack.
- cpu_req and host_req raised in the same cycle, both held → grants alternate CPU, HOST, CPU; each ack is a single pulse and there is no back-to-back double grant to the same requester.
- clear_start with DEPTH = 1024 → 1024 consecutive zero writes at addr 0..1023 → clear_done at start+1025. A subsequent read of addr 1022 returns 0 (preset value was 5).
- host_req raised during CLEAR → no host_ack until the cycle after clear_done + 2. clear_start pulsed during SERVE → CLEAR begins right after that access completes.
- cpu_addr = 0x00000405 → mem_addr = 0x005.
- reset asserted mid-CLEAR at clr_addr = 300 → the next cycle is IDLE with all outputs 0 and no clear_done; addr 301 keeps its old value.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Single owner of the data memory's one read/write port: round-robin CPU/host arbiter plus zero-fill engine.
// Latency: request sampled in IDLE -> memory access next cycle -> one-cycle ack the cycle after (3-cycle issue interval).
// Backpressure: requesters hold req until ack; requests simply wait while a clear is running or the port is busy.
//
// Ports:
//   clk, reset                  : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata       : CPU access request, held until cpu_ack
//   cpu_ack, cpu_rdata          : CPU completion pulse and registered read result
//   host_req/we/addr/wdata      : host loader/debug request, same handshake as CPU
//   host_ack, host_rdata        : host completion pulse and registered read result
//   clear_start                 : pulse requesting a zero-fill of DEPTH words
//   clear_busy, clear_done      : zero-fill in progress / one-cycle completion pulse
//   busy                        : arbiter is serving an access or clearing
//   mem_read/write/addr/wdata   : memory port controls, driven only in SERVE or CLEAR
//   mem_rdata                   : combinational read data from memory
module dmem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [31:0]       host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_CLEAR} state_t;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              clear_pending;
    logic [ADDR_W-1:0] clr_addr;

    logic cpu_elig;
    logic host_elig;
    logic start_clear;
    logic grant_cpu;
    logic grant_host;
    logic grant;
    logic clr_last;

    // Upper address bits are intentionally dropped (addresses wrap modulo 2^ADDR_W).
    logic unused_addr_hi;
    assign unused_addr_hi = ^{cpu_addr[31:ADDR_W], host_addr[31:ADDR_W]};

    // A requester whose ack is high this cycle still holds req; masking it
    // stops the same access from being issued twice.
    assign cpu_elig    = cpu_req & ~cpu_ack;
    assign host_elig   = host_req & ~host_ack;
    assign start_clear = clear_start | clear_pending;

    // Clear has priority over requests; on a tie the requester not granted last wins.
    assign grant_cpu  = (state == S_IDLE) & ~start_clear & cpu_elig &
                        (~host_elig | (last_grant == OWN_HOST));
    assign grant_host = (state == S_IDLE) & ~start_clear & host_elig & ~grant_cpu;
    assign grant      = grant_cpu | grant_host;

    assign clr_last = (clr_addr == ADDR_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_clear) begin
                    state_nxt = S_CLEAR;
                end else if (grant) begin
                    state_nxt = S_SERVE;
                end
            end
            S_SERVE: state_nxt = S_IDLE;
            S_CLEAR: begin
                if (clr_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory port and status outputs
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        clear_busy = 1'b0;
        case (state)
            S_SERVE: begin
                busy      = 1'b1;
                mem_read  = ~lat_we;
                mem_write = lat_we;
                mem_addr  = 32'(lat_addr);
                mem_wdata = lat_wdata;
            end
            S_CLEAR: begin
                busy       = 1'b1;
                clear_busy = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = 32'(clr_addr);
            end
            default: ;
        endcase
    end

    // Request latch, acks, read-data capture and clear bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= OWN_HOST;
            owner         <= OWN_CPU;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            clear_pending <= 1'b0;
            clr_addr      <= '0;
            cpu_ack       <= 1'b0;
            host_ack      <= 1'b0;
            cpu_rdata     <= '0;
            host_rdata    <= '0;
            clear_done    <= 1'b0;
        end else begin
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            clear_done <= 1'b0;

            if (state == S_IDLE && start_clear) begin
                clr_addr      <= '0;
                clear_pending <= 1'b0;
            end

            // A clear arriving mid-access is remembered and started once the access retires.
            if (state == S_SERVE && clear_start) begin
                clear_pending <= 1'b1;
            end

            if (grant) begin
                lat_we     <= grant_cpu ? cpu_we : host_we;
                lat_addr   <= grant_cpu ? cpu_addr[ADDR_W-1:0] : host_addr[ADDR_W-1:0];
                lat_wdata  <= grant_cpu ? cpu_wdata : host_wdata;
                owner      <= grant_host;
                last_grant <= grant_host;
            end

            if (state == S_SERVE) begin
                if (owner == OWN_HOST) begin
                    host_ack <= 1'b1;
                    if (!lat_we) begin
                        host_rdata <= mem_rdata;
                    end
                end else begin
                    cpu_ack <= 1'b1;
                    if (!lat_we) begin
                        cpu_rdata <= mem_rdata;
                    end
                end
            end

            if (state == S_CLEAR) begin
                clr_addr <= clr_addr + ADDR_W'(1);
                if (clr_last) begin
                    clear_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized two-requester run checked against a shadow memory.
// Inputs are driven just after posedge (or at negedge); outputs are sampled at negedge.
module tb_dmem_port_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [31:0]   cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          host_req, host_we, host_ack;
    logic [31:0]   host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          clear_start, clear_busy, clear_done, busy;
    logic          mem_read, mem_write;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [31:0] mem    [0:DEPTH-1];
    logic [31:0] shadow [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        who;        // 0 = CPU, 1 = host
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on posedge.
    assign mem_rdata = mem[mem_addr[AW-1:0]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[AW-1:0]] <= mem_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One uncontended access with exact cycle-by-cycle checks.
    task automatic do_access(input logic who, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_maddr,
                             input logic [31:0] exp_rdata, input string nm);
        @(posedge clk); #1;
        if (who) begin
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        @(negedge clk);
        chk({nm, " idle"}, {30'b0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        chk({nm, " mem_addr"}, mem_addr, exp_maddr);
        chk({nm, " rw"}, {30'b0, mem_write, mem_read}, we ? 32'd2 : 32'd1);
        if (we) chk({nm, " wdata"}, mem_wdata, wdata);
        @(negedge clk);
        chk({nm, " ack"}, {30'b0, cpu_ack, host_ack}, who ? 32'd1 : 32'd2);
        if (!we) chk({nm, " rdata"}, who ? host_rdata : cpu_rdata, exp_rdata);
        @(posedge clk); #1;
        cpu_req  = 1'b0;
        host_req = 1'b0;
        @(negedge clk);
        chk({nm, " ack pulse"}, {30'b0, cpu_ack, host_ack}, 32'd0);
    endtask

    // Random requester; read results are predicted from a shadow memory updated in ack order.
    task automatic rand_driver(input logic who, input int ntx);
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        ack;
        int          cnt;
        for (int n = 0; n < ntx; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << AW);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (who) begin
                host_req = 1'b1; host_we = w; host_addr = a; host_wdata = d;
            end else begin
                cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = d;
            end
            cnt = 0;
            ack = 1'b0;
            while (!ack && cnt < 20) begin
                @(negedge clk);
                cnt++;
                ack = who ? host_ack : cpu_ack;
            end
            chk($sformatf("rand %0d.%0d ack latency ok", who, n),
                {31'b0, ack && cnt >= 3}, 32'd1);
            if (ack) begin
                if (w) begin
                    shadow[a[AW-1:0]] = d;
                end else begin
                    chk($sformatf("rand %0d.%0d rdata", who, n),
                        who ? host_rdata : cpu_rdata, shadow[a[AW-1:0]]);
                end
            end
            @(posedge clk); #1;
            if (who) host_req = 1'b0; else cpu_req = 1'b0;
            @(negedge clk);
            chk($sformatf("rand %0d.%0d ack pulse", who, n),
                {31'b0, who ? host_ack : cpu_ack}, 32'd0);
        end
    endtask

    initial begin
        int nwr, ndone, first_done, first_hack, cnt;
        logic [31:0] hrd;

        vecs[0] = '{1'b0, 1'b1, 32'd5,          32'hDEADBEEF, 32'd5,     32'd0};
        vecs[1] = '{1'b0, 1'b0, 32'd5,          32'd0,        32'd5,     32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0405,  32'h12345678, 32'd5,     32'd0};
        vecs[3] = '{1'b1, 1'b0, 32'd5,          32'd0,        32'd5,     32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFF,  32'hA5A5A5A5, 32'h3FF,   32'd0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_07FF,  32'd0,        32'h3FF,   32'hA5A5A5A5};
        vecs[6] = '{1'b0, 1'b1, 32'd1022,       32'd5,        32'd1022,  32'd0};
        vecs[7] = '{1'b1, 1'b0, 32'd1022,       32'd0,        32'd1022,  32'd5};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0405,  32'd0,        32'd5,     32'h12345678};

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        clear_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset flags", {25'b0, cpu_ack, host_ack, clear_busy, clear_done, busy, mem_read, mem_write}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset cpu_rdata", cpu_rdata, 32'd0);
        chk("reset host_rdata", host_rdata, 32'd0);

        // Contention: both raised together; CPU wins the first tie, then strict alternation.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd7;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'd9;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("contend acks k%0d", k), {30'b0, cpu_ack, host_ack},
                (k == 3 || k == 7) ? 32'd2 : (k == 5 || k == 9) ? 32'd1 : 32'd0);
            if (k == 9) begin
                cpu_req  = 1'b0;
                host_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("contend drained", {31'b0, busy}, 32'd0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            do_access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_maddr, vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end

        // Full clear with a host read raised mid-clear.
        nwr = 0; ndone = 0; first_done = 0; first_hack = 0; hrd = 32'hFFFF_FFFF;
        @(posedge clk); #1 clear_start = 1'b1;
        for (int k = 1; k <= 1030; k++) begin
            @(negedge clk);
            if (k == 2) clear_start = 1'b0;
            if (k == 100) begin
                host_req = 1'b1; host_we = 1'b0; host_addr = 32'd1022;
            end
            if (k >= 2 && k <= 1025) begin
                if (mem_write && !mem_read && mem_addr == 32'(k - 2) && mem_wdata == 0 && clear_busy && busy)
                    nwr++;
            end
            if (k == 1026) chk("clear busy after done", {31'b0, clear_busy}, 32'd0);
            if (clear_done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
            if (host_ack && first_hack == 0) begin
                first_hack = k;
                hrd = host_rdata;
                host_req = 1'b0;
            end
        end
        chk("clear zero writes", nwr, 32'd1024);
        chk("clear_done cycle", first_done, 32'd1026);
        chk("clear_done pulses", ndone, 32'd1);
        chk("host ack after clear", first_hack, 32'd1028);
        chk("host read 1022 after clear", hrd, 32'd0);

        // Clear requested during SERVE, then reset mid-clear at clr_addr 300.
        do_access(1'b0, 1'b1, 32'd301, 32'h77, 32'd301, 32'd0, "preset 301");
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd301;
        for (int k = 1; k <= 304; k++) begin
            @(negedge clk);
            if (k == 2) clear_start = 1'b1;
            if (k == 3) begin
                clear_start = 1'b0;
                cpu_req = 1'b0;
                chk("serve-clear ack", {31'b0, cpu_ack}, 32'd1);
                chk("serve-clear rdata", cpu_rdata, 32'h77);
                chk("serve-clear not yet busy", {31'b0, clear_busy}, 32'd0);
            end
            if (k == 4) begin
                chk("pending clear starts", {29'b0, clear_busy, mem_write, mem_read}, 32'd6);
                chk("pending clear addr0", mem_addr, 32'd0);
            end
            if (k == 304) begin
                chk("clr_addr 300", mem_addr, 32'd300);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        chk("abort flags", {25'b0, cpu_ack, host_ack, clear_busy, clear_done, busy, mem_read, mem_write}, 32'd0);
        chk("abort mem_addr", mem_addr, 32'd0);
        chk("abort cpu_rdata", cpu_rdata, 32'd0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (clear_done || clear_busy) ndone++;
        end
        chk("no clear_done after abort", ndone, 32'd0);
        do_access(1'b0, 1'b0, 32'd301, 32'd0, 32'd301, 32'h77, "addr301 kept");
        do_access(1'b1, 1'b0, 32'd299, 32'd0, 32'd299, 32'd0, "addr299 cleared");

        // Full clear, then randomized traffic from both requesters.
        @(posedge clk); #1 clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        cnt = 0;
        while (!clear_done && cnt < 1100) begin
            @(negedge clk);
            cnt++;
        end
        chk("final clear done", {31'b0, clear_done}, 32'd1);
        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'd0;
        fork
            rand_driver(1'b0, 40);
            rand_driver(1'b1, 40);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
